// File: rtl/bit_count_ctrl_pkg.sv
// bit_count_pkg: types shared by the bit-count controller slice.
// State enum, default datapath width and watchdog sizing helper.
package bit_count_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      DRAIN,
      DONE,
      ERR
   } state_t;

   // Counter width that can hold the value w.
   function automatic int cw_of(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bit_count_ctrl_if.sv
// bit_count_ctrl_if: controller <-> datapath/consumer signals.
// master = controller (drives strobes/status), slave = environment.
interface bit_count_ctrl_if;

   logic s;
   logic z;
   logic a;
   logic Ack;
   logic LA;
   logic LB;
   logic EA;
   logic EB;
   logic Busy;
   logic Done;
   logic Err;

   modport master (
      input  s, z, a, Ack,
      output LA, LB, EA, EB, Busy, Done, Err
   );

   modport slave (
      output s, z, a, Ack,
      input  LA, LB, EA, EB, Busy, Done, Err
   );

endinterface

// File: rtl/bit_count_ctrl_watchdog.sv
// bc_watchdog: saturating shift counter for the bit-count controller.
// Ports: Clk, Resetn, clr, en in; expired out (count == WIDTH).
module bc_watchdog
   import bit_count_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CW    = cw_of(WIDTH)
) (
   input  logic Clk,
   input  logic Resetn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [CW-1:0] LIMIT = CW'(WIDTH);

   logic [CW-1:0] cnt;

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != LIMIT) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/bit_count_ctrl.sv
// bit_count_ctrl: sequences the shift-and-count datapath, Done/Ack out.
// Ports: Clk, Resetn, bus (master: s,z,a,Ack in; LA,LB,EA,EB,Busy,Done,Err out).
module bit_count_ctrl
   import bit_count_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CW    = cw_of(WIDTH)
) (
   input  logic             Clk,
   input  logic             Resetn,
   bit_count_ctrl_if.master bus
);

   state_t state;
   state_t nxt;

   logic start;
   logic wd_exp;
   logic ea_q;
   logic busy_q;
   logic done_q;
   logic err_q;

   assign start = (state == IDLE) && bus.s;

   bc_watchdog #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_wd (
      .Clk     (Clk),
      .Resetn  (Resetn),
      .clr     (start),
      .en      (state == SHIFT),
      .expired (wd_exp)
   );

   // A zero flag wins over an expiring watchdog: a full-width
   // value reaches zero in the same cycle the counter saturates.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (bus.s) nxt = SHIFT;
         SHIFT: begin
            if (bus.z)       nxt = DRAIN;
            else if (wd_exp) nxt = ERR;
         end
         DRAIN: nxt = DONE;
         DONE:  if (bus.Ack) nxt = IDLE;
         ERR:   if (bus.Ack) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Moore outputs are registered from the next state so they
   // change only on the clock edge, aligned with the state.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state  <= IDLE;
         ea_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= nxt;
         ea_q   <= (nxt == SHIFT);
         busy_q <= (nxt == SHIFT) || (nxt == DRAIN);
         done_q <= (nxt == DONE);
         err_q  <= (nxt == ERR);
      end
   end

   // Load/clear are gated by reset so s cannot leak through.
   assign bus.LA   = Resetn && start;
   assign bus.LB   = Resetn && start;
   assign bus.EA   = ea_q;
   assign bus.EB   = ((state == SHIFT) || (state == DRAIN)) && bus.a;
   assign bus.Busy = busy_q;
   assign bus.Done = done_q;
   assign bus.Err  = err_q;

endmodule

// File: tb/tb_bit_count_ctrl.sv
// tb_bit_count_ctrl: directed bench for bit_count_ctrl with a
// shift-right counter datapath as the load and a phase-level model.
module tb_bit_count_ctrl;
   import bit_count_pkg::*;

   localparam int W = 4;
   localparam int P_IDLE  = 0;
   localparam int P_SHIFT = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;
   localparam int P_ERR   = 4;

   logic         Clk    = 1'b0;
   logic         Resetn = 1'b0;
   logic         s      = 1'b0;
   logic         Ack    = 1'b0;
   logic [W-1:0] D      = '0;
   logic         zf_en  = 1'b0;
   logic         zf_val = 1'b0;
   logic         af_en  = 1'b0;
   logic         af_val = 1'b0;

   logic [W-1:0] A;
   logic         areg;
   logic [2:0]   B;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ph    = P_IDLE;
   int ea_cnt = 0;
   int eb_cnt = 0;
   int start_cyc = 0;
   int term_cyc  = -1;

   bit_count_ctrl_if bus ();

   assign bus.s   = s;
   assign bus.Ack = Ack;
   assign bus.z   = zf_en ? zf_val : (A == '0);
   assign bus.a   = af_en ? af_val : areg;

   bit_count_ctrl #(.WIDTH(W)) dut (
      .Clk    (Clk),
      .Resetn (Resetn),
      .bus    (bus)
   );

   always #5 Clk = ~Clk;

   // Counter datapath: A shifts right with 0 in, areg holds the
   // bit shifted out, B counts EB strobes.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         A    <= '0;
         areg <= 1'b0;
         B    <= '0;
      end else begin
         if (bus.LA) begin
            A    <= D;
            areg <= 1'b0;
         end else if (bus.EA) begin
            A    <= A >> 1;
            areg <= A[0];
         end
         if (bus.LB)      B <= '0;
         else if (bus.EB) B <= B + 3'd1;
      end
   end

   logic [6:0] outs;
   assign outs = {bus.LA, bus.LB, bus.EA, bus.EB,
                  bus.Busy, bus.Done, bus.Err};

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Shifts needed to empty A: index of highest set bit plus one.
   function automatic int shifts_of(input logic [W-1:0] d);
      int n = 0;
      for (int i = 0; i < W; i++) if (d[i]) n = i + 1;
      return n;
   endfunction

   // Expected outputs follow from the current phase and inputs.
   task automatic cmp_cycle();
      logic e_la, e_sh, e_eb, e_bsy, e_dn, e_er;
      logic [6:0] eo;
      e_la  = Resetn && (ph == P_IDLE) && s;
      e_sh  = (ph == P_SHIFT);
      e_bsy = (ph == P_SHIFT) || (ph == P_DRAIN);
      e_eb  = Resetn && e_bsy && bus.a;
      e_dn  = (ph == P_DONE);
      e_er  = (ph == P_ERR);
      eo = {e_la, e_la, e_sh, e_eb, e_bsy, e_dn, e_er};
      chk("outs", 32'(outs), 32'(eo));
      cyc++;
      if (bus.LA) begin
         start_cyc = cyc;
         ea_cnt    = 0;
         eb_cnt    = 0;
         term_cyc  = -1;
      end
      ea_cnt += int'(bus.EA);
      eb_cnt += int'(bus.EB);
      if ((bus.Done || bus.Err) && term_cyc < 0) term_cyc = cyc;
   endtask

   task automatic step();
      @(negedge Clk);
      cmp_cycle();
      @(posedge Clk);
      #1;
   endtask

   // mode 0: real datapath; 1: z stuck 0; 2: z and a stuck 1.
   task automatic run(input logic [W-1:0] d, input int mode,
                      input bit s_hold, input bit ack_shift,
                      input int ack_wait, output int lat,
                      output int ean, output int ebn, output int bv);
      int nsh;
      nsh = (mode == 1) ? W : (mode == 2) ? 0 : shifts_of(d);
      D      = d;
      zf_en  = (mode != 0);
      zf_val = (mode == 2);
      af_en  = (mode == 2);
      af_val = 1'b1;
      s      = 1'b1;
      Ack    = 1'b0;
      ph     = P_IDLE;
      for (int i = 0; i <= nsh; i++) begin
         step();
         s   = s_hold;
         Ack = ack_shift;
         ph  = P_SHIFT;
      end
      step();
      Ack = 1'b0;
      if (mode == 1) begin
         ph = P_ERR;
      end else begin
         ph = P_DRAIN;
         step();
         ph = P_DONE;
      end
      bv = int'(B);
      if (mode == 0) chk("B_popcount", 32'(bv), 32'($countones(d)));
      for (int j = 0; j < ack_wait; j++) step();
      Ack = 1'b1;
      step();
      lat = term_cyc - start_cyc - 1;
      ean = ea_cnt;
      ebn = eb_cnt;
      Ack = 1'b0;
      ph  = P_IDLE;
      s   = s_hold;
   endtask

   initial begin
      int lat, ean, ebn, bv;

      // reset held with s high: Mealy strobes must stay low
      s = 1'b1;
      step();
      step();
      Resetn = 1'b1;
      s = 1'b0;
      step();

      run(4'b1011, 0, 1'b0, 1'b1, 2, lat, ean, ebn, bv);
      chk("t1011_lat", 32'(lat), 32'd6);
      chk("t1011_ea",  32'(ean), 32'd5);
      chk("t1011_eb",  32'(ebn), 32'd3);
      chk("t1011_B",   32'(bv),  32'd3);
      step();

      run(4'b0000, 0, 1'b0, 1'b0, 0, lat, ean, ebn, bv);
      chk("t0000_lat", 32'(lat), 32'd2);
      chk("t0000_ea",  32'(ean), 32'd1);
      chk("t0000_eb",  32'(ebn), 32'd0);
      chk("t0000_B",   32'(bv),  32'd0);
      step();

      run(4'b1111, 0, 1'b0, 1'b0, 1, lat, ean, ebn, bv);
      chk("t1111_lat", 32'(lat), 32'd6);
      chk("t1111_ea",  32'(ean), 32'd5);
      chk("t1111_eb",  32'(ebn), 32'd4);
      chk("t1111_B",   32'(bv),  32'd4);
      step();

      run(4'b1111, 1, 1'b0, 1'b0, 3, lat, ean, ebn, bv);
      chk("wdog_lat", 32'(lat), 32'd5);
      chk("wdog_ea",  32'(ean), 32'd5);
      step();

      run(4'b0000, 2, 1'b0, 1'b0, 1, lat, ean, ebn, bv);
      chk("drain_lat", 32'(lat), 32'd2);
      chk("drain_eb",  32'(ebn), 32'd2);
      step();

      // back-to-back starts with s held and Ack on first Done
      run(4'b0101, 0, 1'b1, 1'b0, 0, lat, ean, ebn, bv);
      chk("b2b0_lat", 32'(lat), 32'd5);
      chk("b2b0_B",   32'(bv),  32'd2);
      run(4'b0110, 0, 1'b1, 1'b0, 1, lat, ean, ebn, bv);
      chk("b2b1_B",   32'(bv),  32'd2);
      run(4'b0001, 0, 1'b0, 1'b0, 0, lat, ean, ebn, bv);
      chk("b2b2_lat", 32'(lat), 32'd3);
      chk("b2b2_B",   32'(bv),  32'd1);
      step();

      // asynchronous reset in the middle of a count
      D      = 4'b1011;
      zf_en  = 1'b0;
      af_en  = 1'b0;
      s      = 1'b1;
      ph     = P_IDLE;
      step();
      ph = P_SHIFT;
      step();
      #2;
      Resetn = 1'b0;
      ph     = P_IDLE;
      #1;
      chk("rst_async", 32'(outs), 32'd0);
      step();
      Resetn = 1'b1;
      s      = 1'b0;
      for (int i = 0; i < 3; i++) step();

      run(4'b0110, 0, 1'b0, 1'b0, 0, lat, ean, ebn, bv);
      chk("post_rst_B",   32'(bv),  32'd2);
      chk("post_rst_lat", 32'(lat), 32'd5);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
